// File: rtl/s386_bist_pkg.sv
// Shared types and helpers for the s386 cone BIST controller.
// Latency: n/a (package only: state encoding, polynomial taps, step function).
// Backpressure: n/a.
package s386_bist_pkg;

  // Controller states; busy covers SEED through COMPARE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    APPLY   = 3'd2,
    CAPTURE = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } bist_state_e;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: the feedback
  // bit is the XOR of register bits 0, 2, 3 and 5.
  localparam int unsigned TAP_0 = 0;
  localparam int unsigned TAP_1 = 2;
  localparam int unsigned TAP_2 = 3;
  localparam int unsigned TAP_3 = 5;
  localparam logic [15:0] TAP_MASK = (16'd1 << TAP_0) | (16'd1 << TAP_1) |
                                     (16'd1 << TAP_2) | (16'd1 << TAP_3);

  // One shift of the shared polynomial; used by both the TPG and the MISR.
  function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
    logic fb;
    fb = ^(s & TAP_MASK);
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/s386_cone_bist_ctrl_misr.sv
// 16-bit multiple-input signature register compacting cone responses.
// Latency: 1 cycle from en to updated sig; clear wins over en.
// Backpressure: none; ports clk, rst_n (sync, active-low), clear, en, data[PO_W], sig[16].
module bist_misr16
  import s386_bist_pkg::*;
#(
  parameter int PO_W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            en,
  input  logic [PO_W-1:0] data,
  output logic [15:0]     sig
);

  logic [15:0] sig_q;
  logic [15:0] data_ext;

  // Responses land in the low bits; written this way so PO_W=16 needs no
  // zero-width replication.
  always_comb begin
    data_ext = '0;
    data_ext[PO_W-1:0] = data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (clear) begin
      sig_q <= '0;
    end else if (en) begin
      sig_q <= lfsr16_step(sig_q) ^ data_ext;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/s386_cone_bist_ctrl.sv
// BIST controller for s386 cones: LFSR patterns, settle, capture into MISR, golden compare.
// Latency: done rises NUM_PATTERNS*(SETTLE_CYCLES+1)+2 cycles after the edge sampling start.
// Backpressure: none; start ignored while busy, abort always wins and returns to IDLE.
// Ports: clk, rst_n (sync, active-low), start, abort, golden_sig[16], response_i[PO_W]
//        -> pattern_o[PI_W], busy, done, pass, signature[16].
module s386_cone_bist_ctrl
  import s386_bist_pkg::*;
#(
  parameter int          PI_W          = 12,
  parameter int          PO_W          = 1,
  parameter int          NUM_PATTERNS  = 256,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [15:0]     golden_sig,
  output logic [PI_W-1:0] pattern_o,
  input  logic [PO_W-1:0] response_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature
);

  localparam logic [15:0] LAST_CNT    = 16'(NUM_PATTERNS - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  bist_state_e     state_q;
  bist_state_e     state_d;
  logic [15:0]     lfsr_q;
  logic [15:0]     lfsr_nx;
  logic [15:0]     cnt_q;
  logic [3:0]      settle_q;
  logic            pass_q;
  logic [PI_W-1:0] pattern_q;
  logic [PI_W-1:0] pattern_d;
  logic            last_pattern;
  logic            settle_end;
  logic            misr_clear;
  logic            misr_en;
  logic [15:0]     misr_sig;

  assign last_pattern = (cnt_q == LAST_CNT);
  assign settle_end   = (settle_q == SETTLE_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = SEED;
        SEED:    state_d = APPLY;
        APPLY:   if (settle_end) state_d = CAPTURE;
        CAPTURE: state_d = last_pattern ? COMPARE : APPLY;
        COMPARE: state_d = DONE;
        DONE:    if (start) state_d = SEED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      SEED, APPLY, CAPTURE, COMPARE: busy = 1'b1;
      DONE:                          done = 1'b1;
      default:                       ;
    endcase
  end

  // ------------------------------------------------------------ datapath
  // Value the TPG register takes at the coming edge (ignoring abort, which
  // freezes it). The pattern register is loaded from this so that pattern_o
  // already shows the new vector on the first APPLY cycle.
  always_comb begin
    lfsr_nx = lfsr_q;
    if (state_q == SEED) begin
      lfsr_nx = LFSR_SEED;
    end else if (state_q == CAPTURE) begin
      lfsr_nx = lfsr16_step(lfsr_q);
    end
  end

  always_comb begin
    pattern_d = '0;
    if (state_d == APPLY || state_d == CAPTURE) begin
      pattern_d = lfsr_nx[PI_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q    <= LFSR_SEED;
      cnt_q     <= '0;
      settle_q  <= '0;
      pass_q    <= 1'b0;
      pattern_q <= '0;
    end else begin
      pattern_q <= pattern_d;
      // An abort freezes every run register; only the state moves.
      if (!abort) begin
        lfsr_q <= lfsr_nx;
        unique case (state_q)
          SEED: begin
            cnt_q    <= '0;
            settle_q <= '0;
          end
          APPLY: begin
            settle_q <= settle_q + 4'd1;
          end
          CAPTURE: begin
            if (!last_pattern) begin
              cnt_q    <= cnt_q + 16'd1;
              settle_q <= '0;
            end
          end
          COMPARE: begin
            pass_q <= (misr_sig == golden_sig);
          end
          default: ;
        endcase
      end
    end
  end

  assign misr_clear = (state_q == SEED)    && !abort;
  assign misr_en    = (state_q == CAPTURE) && !abort;

  bist_misr16 #(
    .PO_W (PO_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (misr_clear),
    .en    (misr_en),
    .data  (response_i),
    .sig   (misr_sig)
  );

  assign pattern_o = pattern_q;
  assign pass      = pass_q;
  assign signature = misr_sig;

endmodule
